// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered RV instruction decode stage sitting between fetch and execute.
// Decodes the instruction, builds one sign-extended immediate and the
// branch/jump target, and buffers up to two decoded entries (main + skid)
// so the upstream side keeps full throughput under downstream backpressure.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   drop every buffered entry (branch redirect)
//   in_valid/in_ready       fetch handshake; in_ready is registered
//   in_instr, in_pc         raw instruction and its pc
//   out_valid/out_ready     execute handshake
//   out_op_type             decoded class
//   out_rs1/out_rs2/out_rd  register indices, 0 when the format lacks them
//   out_imm                 unified sign-extended immediate
//   out_pc, out_target      entry pc; pc + imm for BEQ/BNE/BLT/BGE/JAL
//   out_illegal             op_type == ERR
//
// Optional build macro: DECODE_PERF_EN
//   Adds perf_decoded / perf_illegal saturating 32-bit handshake counters.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | nothing buffered, out_valid = 0
// ONE   | main register valid, skid empty
// TWO   | main and skid valid, in_ready = 0
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int OPT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPT_W-1:0] out_op_type,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]      perf_decoded,
    output logic [31:0]      perf_illegal
`endif
);

    localparam logic [OPT_W-1:0] OP_NULL  = OPT_W'(0);
    localparam logic [OPT_W-1:0] OP_ADD   = OPT_W'(1);
    localparam logic [OPT_W-1:0] OP_ADDI  = OPT_W'(2);
    localparam logic [OPT_W-1:0] OP_ADDW  = OPT_W'(3);
    localparam logic [OPT_W-1:0] OP_BEQ   = OPT_W'(4);
    localparam logic [OPT_W-1:0] OP_BNE   = OPT_W'(5);
    localparam logic [OPT_W-1:0] OP_BLT   = OPT_W'(6);
    localparam logic [OPT_W-1:0] OP_LW    = OPT_W'(7);
    localparam logic [OPT_W-1:0] OP_SW    = OPT_W'(8);
    localparam logic [OPT_W-1:0] OP_JAL   = OPT_W'(9);
    localparam logic [OPT_W-1:0] OP_SUB   = OPT_W'(10);
    localparam logic [OPT_W-1:0] OP_LUI   = OPT_W'(11);
    localparam logic [OPT_W-1:0] OP_AUIPC = OPT_W'(12);
    localparam logic [OPT_W-1:0] OP_JALR  = OPT_W'(13);
    localparam logic [OPT_W-1:0] OP_BGE   = OPT_W'(14);
    localparam logic [OPT_W-1:0] OP_ERR   = OPT_W'(31);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [OPT_W-1:0] op;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  target;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    // Every immediate format is first sign-extended to 32 bits, then widened.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    // ---------------- decode ----------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm32;
    logic        has_target;
    entry_t      dec;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        imm32      = '0;
        has_target = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP32: begin
                if (opcode == OPC_OP32) begin
                    dec.op = OP_ADDW;
                end else begin
                    dec.op = (funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
                end
                dec.rd  = in_instr[11:7];
                dec.rs1 = in_instr[19:15];
                dec.rs2 = in_instr[24:20];
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                if (opcode == OPC_OPIMM)     dec.op = OP_ADDI;
                else if (opcode == OPC_LOAD) dec.op = OP_LW;
                else                         dec.op = OP_JALR;
                dec.rd  = in_instr[11:7];
                dec.rs1 = in_instr[19:15];
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                dec.op  = OP_SW;
                dec.rs1 = in_instr[19:15];
                dec.rs2 = in_instr[24:20];
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  dec.op = OP_BEQ;
                    3'b001:  dec.op = OP_BNE;
                    3'b100:  dec.op = OP_BLT;
                    3'b101:  dec.op = OP_BGE;
                    default: dec.op = OP_ERR;
                endcase
                if (dec.op != OP_ERR) begin
                    dec.rs1    = in_instr[19:15];
                    dec.rs2    = in_instr[24:20];
                    imm32      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0};
                    has_target = 1'b1;
                end
            end
            OPC_JAL: begin
                dec.op     = OP_JAL;
                dec.rd     = in_instr[11:7];
                imm32      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
                has_target = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.op = (opcode == OPC_LUI) ? OP_LUI : OP_AUIPC;
                dec.rd = in_instr[11:7];
                imm32  = {in_instr[31:12], 12'b0};
            end
            default: begin
                dec.op = (in_instr == 32'd0) ? OP_NULL : OP_ERR;
            end
        endcase
        dec.imm    = sext32(imm32);
        dec.target = has_target ? (in_pc + dec.imm) : '0;
    end

    // ---------------- skid buffer FSM ----------------
    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && out_ready) begin
                        main_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = S_TWO;
                    end else if (out_ready) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        // Registered ready: a pure function of the next state, so there is
        // no combinational path from out_ready to in_ready.
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != S_EMPTY);
    assign out_op_type = main_q.op;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_imm     = main_q.imm;
    assign out_pc      = main_q.pc;
    assign out_target  = main_q.target;
    assign out_illegal = (main_q.op == OP_ERR);

`ifdef DECODE_PERF_EN
    logic [31:0] perf_decoded_q, perf_decoded_d;
    logic [31:0] perf_illegal_q, perf_illegal_d;
    logic        out_fire;

    assign out_fire = out_valid && out_ready;

    always_comb begin
        perf_decoded_d = perf_decoded_q;
        perf_illegal_d = perf_illegal_q;
        if (out_fire && (perf_decoded_q != 32'hFFFF_FFFF)) begin
            perf_decoded_d = perf_decoded_q + 32'd1;
        end
        if (out_fire && out_illegal && (perf_illegal_q != 32'hFFFF_FFFF)) begin
            perf_illegal_d = perf_illegal_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded_q <= '0;
            perf_illegal_q <= '0;
        end else begin
            perf_decoded_q <= perf_decoded_d;
            perf_illegal_q <= perf_illegal_d;
        end
    end

    assign perf_decoded = perf_decoded_q;
    assign perf_illegal = perf_illegal_q;
`endif

endmodule
